// File: rtl/snn_pkg.sv
// Shared spiking-network definitions: default datapath width, neuron state encoding,
// and the signed saturation helper reused by the synapse stages.
package snn_pkg;

  localparam int SNN_WIDTH = 8;

  typedef enum logic {
    ST_INTEGRATE  = 1'b0,
    ST_REFRACTORY = 1'b1
  } lif_state_t;

  // Clamps x into the signed range of a w-bit value; the caller narrows the result.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] x, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/lif_leak_sat.sv
// Combinational membrane update: Vn = sat(V - (V >>> shift) + I), shift of 0 disables leak.
// Zero latency, no handshake.
module lif_leak_sat
  import snn_pkg::*;
#(
  parameter int WIDTH   = SNN_WIDTH,
  parameter int SHIFT_W = 3
) (
  input  logic signed [WIDTH-1:0]   i_v,
  input  logic signed [WIDTH-1:0]   i_current,
  input  logic        [SHIFT_W-1:0] i_decay_shift,
  output logic signed [WIDTH-1:0]   o_vn
);

  logic signed [WIDTH-1:0] w_leak;
  logic signed [WIDTH+1:0] w_sum;

  // A zero shift would otherwise leak the whole potential away.
  always_comb begin
    w_leak = '0;
    if (i_decay_shift != '0) w_leak = i_v >>> i_decay_shift;
  end

  assign w_sum = (WIDTH+2)'(i_v) - (WIDTH+2)'(w_leak) + (WIDTH+2)'(i_current);
  assign o_vn  = WIDTH'(saturate(32'(w_sum), WIDTH));

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron; outputs update one clock after each enabled timestep.
// No backpressure: enable=0 freezes all state and forces spike_out low.
module lif_neuron
  import snn_pkg::*;
#(
  parameter int WIDTH   = SNN_WIDTH,
  parameter int REF_W   = 4,
  parameter int SHIFT_W = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic signed [WIDTH-1:0]   input_current,
  input  logic signed [WIDTH-1:0]   threshold,
  input  logic        [SHIFT_W-1:0] decay_shift,
  input  logic        [REF_W-1:0]   refractory_period,
  output logic                      spike_out,
  output logic signed [WIDTH-1:0]   membrane_potential,
  output logic                      refractory
);

  lif_state_t              r_state;
  lif_state_t              w_state_nxt;
  logic signed [WIDTH-1:0] r_v;
  logic signed [WIDTH-1:0] w_v_nxt;
  logic signed [WIDTH-1:0] w_vn;
  logic [REF_W-1:0]        r_cnt;
  logic [REF_W-1:0]        w_cnt_nxt;
  logic                    r_spike;
  logic                    w_spike_nxt;

  lif_leak_sat #(
    .WIDTH   (WIDTH),
    .SHIFT_W (SHIFT_W)
  ) u_leak_sat (
    .i_v           (r_v),
    .i_current     (input_current),
    .i_decay_shift (decay_shift),
    .o_vn          (w_vn)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_INTEGRATE;
      r_v     <= '0;
      r_cnt   <= '0;
      r_spike <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_v     <= w_v_nxt;
      r_cnt   <= w_cnt_nxt;
      r_spike <= w_spike_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_v_nxt     = r_v;
    w_cnt_nxt   = r_cnt;
    w_spike_nxt = 1'b0;
    if (enable) begin
      case (r_state)
        ST_INTEGRATE: begin
          if (w_vn >= threshold) begin
            w_v_nxt     = '0;
            w_spike_nxt = 1'b1;
            if (refractory_period != '0) begin
              w_state_nxt = ST_REFRACTORY;
              w_cnt_nxt   = refractory_period;
            end
          end else begin
            w_v_nxt = w_vn;
          end
        end
        ST_REFRACTORY: begin
          w_v_nxt   = '0;
          w_cnt_nxt = r_cnt - REF_W'(1);
          // The <= also recovers from a zero count, which normal operation never loads.
          if (r_cnt <= REF_W'(1)) w_state_nxt = ST_INTEGRATE;
        end
        default: w_state_nxt = ST_INTEGRATE;
      endcase
    end
  end

  assign spike_out          = r_spike;
  assign membrane_potential = r_v;
  assign refractory         = (r_state == ST_REFRACTORY);

endmodule

// File: tb/tb_lif_neuron.sv
// Directed-vector bench for lif_neuron; expectations queued at issue, compared by a monitor.
module tb_lif_neuron;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic signed [7:0] input_current = '0;
  logic signed [7:0] threshold = '0;
  logic        [2:0] decay_shift = '0;
  logic        [3:0] refractory_period = '0;
  logic              spike_out;
  logic signed [7:0] membrane_potential;
  logic              refractory;

  typedef struct {
    logic              spk;
    logic signed [7:0] v;
    logic              refr;
    int                tag;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_errors = 0;

  lif_neuron dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .enable             (enable),
    .input_current      (input_current),
    .threshold          (threshold),
    .decay_shift        (decay_shift),
    .refractory_period  (refractory_period),
    .spike_out          (spike_out),
    .membrane_potential (membrane_potential),
    .refractory         (refractory)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One enabled timestep followed by one idle clock.
  task automatic step(input int cur, input int thr, input int sh, input int rp,
                      input int es, input int ev, input int er, input int tag);
    exp_t e;
    @(negedge clk);
    input_current     = 8'(cur);
    threshold         = 8'(thr);
    decay_shift       = 3'(sh);
    refractory_period = 4'(rp);
    enable            = 1'b1;
    e.spk  = es[0];
    e.v    = 8'(ev);
    e.refr = er[0];
    e.tag  = tag;
    q.push_back(e);
    @(negedge clk);
    enable = 1'b0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (enable && reset_n) begin
        #1;
        if (q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output: got an enabled step, expected none queued");
        end else begin
          e = q.pop_front();
          check($sformatf("step%0d.spike", e.tag), int'(spike_out), int'(e.spk));
          check($sformatf("step%0d.v", e.tag), int'(membrane_potential), int'(e.v));
          check($sformatf("step%0d.refr", e.tag), int'(refractory), int'(e.refr));
        end
      end
    end
  end

  initial begin
    #3;
    check("reset.v", int'(membrane_potential), 0);
    check("reset.spike", int'(spike_out), 0);
    check("reset.refr", int'(refractory), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Integrate to fire
    step(20, 50, 0, 0, 0, 20, 0, 1);
    step(20, 50, 0, 0, 0, 40, 0, 2);
    step(20, 50, 0, 0, 1,  0, 0, 3);
    @(negedge clk);
    check("fire.pulse_width", int'(spike_out), 0);

    // Leak
    step(100, 127, 1, 0, 0, 100, 0, 4);
    step(  0, 127, 1, 0, 0,  50, 0, 5);
    step(  0, 127, 1, 0, 0,  25, 0, 6);

    // Positive saturation
    step(-25, 127, 0, 0, 0,   0, 0, 7);
    step(100, 127, 0, 0, 0, 100, 0, 8);
    step(100, 127, 0, 0, 1,   0, 0, 9);

    // Negative saturation
    step(-128, 127, 1, 0, 0, -128, 0, 10);
    step(-128, 127, 1, 0, 0, -128, 0, 11);
    step(-128, 127, 0, 0, 0, -128, 0, 12);
    step( 127, 127, 0, 0, 0,   -1, 0, 13);
    step(   1, 127, 0, 0, 0,    0, 0, 14);

    // Enable gating
    step(30, 50, 0, 0, 0, 30, 0, 15);
    input_current = 8'sd100;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("gate%0d.v", i), int'(membrane_potential), 30);
      check($sformatf("gate%0d.spike", i), int'(spike_out), 0);
    end
    step( 10, 50, 0, 0, 0, 40, 0, 16);
    step(-40, 50, 0, 0, 0,  0, 0, 17);

    // Refractory, with a gated gap and a mid-refractory period change
    step(60, 50, 0,  2, 1, 0, 1, 18);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("refgate%0d.refr", i), int'(refractory), 1);
    end
    step(60, 50, 0, 15, 0, 0, 1, 19);
    step(60, 50, 0,  2, 0, 0, 0, 20);
    step(60, 50, 0,  2, 1, 0, 1, 21);

    // Async reset between edges with counter=2
    #2;
    reset_n = 1'b0;
    #1;
    check("arst.v", int'(membrane_potential), 0);
    check("arst.spike", int'(spike_out), 0);
    check("arst.refr", int'(refractory), 0);
    @(negedge clk);
    reset_n = 1'b1;
    step(20, 50, 0, 2, 0, 20, 0, 22);

    // Threshold at or below resting potential fires every step
    step( 0,   0, 0, 0, 1, 0, 0, 23);
    step( 0,   0, 0, 0, 1, 0, 0, 24);
    step(-5, -10, 0, 0, 1, 0, 0, 25);

    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
